// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with bypassed reads, busy-bit scoreboard and debug readout
module reg_file_sb #(
    parameter int XLEN = 64,
    parameter int NREGS = 32,
    parameter int DBG_W = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [XLEN-1:0]  read_data1,
    output logic [XLEN-1:0]  read_data2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    output logic             iss_waw,
    input  logic             flush,
    output logic [AW:0]      busy_count,
    input  logic [AW-1:0]    debug_reg,
    output logic [DBG_W-1:0] debug_data
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy, busy_nxt;
    logic             hit1, hit2, hit_iss;

    assign hit1       = wb_en && wb_rd == rs1;
    assign hit2       = wb_en && wb_rd == rs2;
    assign hit_iss    = wb_en && wb_rd == iss_rd;
    assign read_data1 = (rs1 == '0) ? '0 : hit1 ? wb_data : regs[rs1];
    assign read_data2 = (rs2 == '0) ? '0 : hit2 ? wb_data : regs[rs2];
    assign rs1_busy   = busy[rs1] && !hit1;
    assign rs2_busy   = busy[rs2] && !hit2;
    assign iss_waw    = iss_en && iss_rd != '0 && busy[iss_rd] && !hit_iss;

    // Next busy vector: write-back clears, flush wipes, issue sets last so the newest producer wins
    always_comb begin
        busy_nxt = busy;
        if (wb_en) busy_nxt[wb_rd] = 1'b0;
        if (flush) busy_nxt = '0;
        if (iss_en && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    end

    // Register array; index 0 is never written so it always reads back as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Scoreboard state, its popcount and the debug readout (pre-write array contents)
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
            debug_data <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= (AW+1)'($countones(busy_nxt));
            debug_data <= (debug_reg == '0) ? '0 : regs[debug_reg][DBG_W-1:0];
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table plus randomized run against a reference model
module tb_reg_file_sb;
    localparam int XLEN = 64;
    localparam int NREGS = 32;
    localparam int DBG_W = 8;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             reset, wb_en, iss_en, flush;
    logic [AW-1:0]    rs1, rs2, wb_rd, iss_rd, debug_reg;
    logic [XLEN-1:0]  wb_data, read_data1, read_data2;
    logic             rs1_busy, rs2_busy, iss_waw;
    logic [AW:0]      busy_count;
    logic [DBG_W-1:0] debug_data;

    int checks = 0;
    int failures = 0;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .DBG_W(DBG_W)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
        .read_data1(read_data1), .read_data2(read_data2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_waw(iss_waw),
        .flush(flush), .busy_count(busy_count),
        .debug_reg(debug_reg), .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst, wbe, isse, fl;
        logic [AW-1:0]    wrd, ird, rs1, rs2, dbg;
        logic [XLEN-1:0]  wdata, e_rd1, e_rd2;
        logic             e_b1, e_b2, e_waw;
        int               e_cnt;
        logic [DBG_W-1:0] e_dbg;
    } vec_t;

    // Architectural model: register values and the set of registers awaiting write-back
    logic [XLEN-1:0]  mregs [NREGS];
    bit               mbusy [NREGS];
    logic [DBG_W-1:0] mdbg;
    int               mcnt;

    function automatic vec_t row(int rst, int wbe, int wrd, logic [XLEN-1:0] wdata, int isse,
                                 int ird, int fl, int r1, int r2, int dbg,
                                 logic [XLEN-1:0] erd1, logic [XLEN-1:0] erd2,
                                 int eb1, int eb2, int ewaw, int ecnt, int edbg);
        vec_t v;
        v.rst = rst[0]; v.wbe = wbe[0]; v.wrd = AW'(wrd); v.wdata = wdata;
        v.isse = isse[0]; v.ird = AW'(ird); v.fl = fl[0];
        v.rs1 = AW'(r1); v.rs2 = AW'(r2); v.dbg = AW'(dbg);
        v.e_rd1 = erd1; v.e_rd2 = erd2; v.e_b1 = eb1[0]; v.e_b2 = eb2[0];
        v.e_waw = ewaw[0]; v.e_cnt = ecnt; v.e_dbg = DBG_W'(edbg);
        return v;
    endfunction

    function automatic logic [XLEN-1:0] model_read(logic [AW-1:0] r, vec_t v);
        if (r == 0) return '0;
        if (v.wbe && v.wrd == r) return v.wdata;
        return mregs[r];
    endfunction

    function automatic logic model_pending(logic [AW-1:0] r, vec_t v);
        return mbusy[r] && !(v.wbe && v.wrd == r);
    endfunction

    task automatic model_step(input vec_t v);
        if (v.rst) begin
            foreach (mregs[i]) begin mregs[i] = '0; mbusy[i] = 0; end
            mdbg = '0;
        end else begin
            mdbg = (v.dbg == 0) ? '0 : mregs[v.dbg][DBG_W-1:0];
            if (v.wbe && v.wrd != 0) mregs[v.wrd] = v.wdata;
            if (v.wbe) mbusy[v.wrd] = 0;
            if (v.fl) foreach (mbusy[i]) mbusy[i] = 0;
            if (v.isse && v.ird != 0) mbusy[v.ird] = 1;
        end
        mcnt = 0;
        foreach (mbusy[i]) mcnt += int'(mbusy[i]);
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registered outputs
    task automatic run(input vec_t v, input bit chk_pre, input bit use_model);
        vec_t e = v;
        @(negedge clk);
        reset = v.rst; wb_en = v.wbe; wb_rd = v.wrd; wb_data = v.wdata;
        iss_en = v.isse; iss_rd = v.ird; flush = v.fl;
        rs1 = v.rs1; rs2 = v.rs2; debug_reg = v.dbg;
        if (use_model) begin
            e.e_rd1 = model_read(v.rs1, v);
            e.e_rd2 = model_read(v.rs2, v);
            e.e_b1 = model_pending(v.rs1, v);
            e.e_b2 = model_pending(v.rs2, v);
            e.e_waw = v.isse && v.ird != 0 && model_pending(v.ird, v);
        end
        #1;
        if (chk_pre) begin
            check("read_data1", read_data1, e.e_rd1);
            check("read_data2", read_data2, e.e_rd2);
            check("rs1_busy", XLEN'(rs1_busy), XLEN'(e.e_b1));
            check("rs2_busy", XLEN'(rs2_busy), XLEN'(e.e_b2));
            check("iss_waw", XLEN'(iss_waw), XLEN'(e.e_waw));
        end
        @(posedge clk);
        model_step(v);
        if (use_model) begin e.e_cnt = mcnt; e.e_dbg = mdbg; end
        #1;
        check("busy_count", XLEN'(busy_count), XLEN'(e.e_cnt));
        check("debug_data", XLEN'(debug_data), XLEN'(e.e_dbg));
    endtask

    function automatic logic [AW-1:0] pick();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS-1)) : AW'($urandom_range(0, 7));
    endfunction

    localparam logic [XLEN-1:0] D = 64'hDEADBEEF_00000001;
    vec_t tbl [17];

    initial begin
        reset = 1'b1; wb_en = 0; iss_en = 0; flush = 0;
        rs1 = '0; rs2 = '0; wb_rd = '0; iss_rd = '0; debug_reg = '0; wb_data = '0;
        foreach (mregs[i]) begin mregs[i] = '0; mbusy[i] = 0; end
        mdbg = '0; mcnt = 0;

        //            rst wb rd wdata    is ird fl r1 r2 dbg  rd1     rd2     b1 b2 waw cnt dbg
        tbl[0]  = row(0, 1, 5, D,       0, 0,  0, 5, 5, 5,   D,      D,      0, 0, 0,  0, 0);
        tbl[1]  = row(0, 0, 0, 0,       0, 0,  0, 5, 0, 5,   D,      0,      0, 0, 0,  0, 'h01);
        tbl[2]  = row(0, 1, 0, 'h1234,  1, 0,  0, 0, 5, 0,   0,      D,      0, 0, 0,  0, 0);
        tbl[3]  = row(0, 0, 0, 0,       1, 3,  0, 5, 3, 5,   D,      0,      0, 0, 0,  1, 'h01);
        tbl[4]  = row(0, 0, 0, 0,       0, 0,  0, 3, 3, 0,   0,      0,      1, 1, 0,  1, 0);
        tbl[5]  = row(0, 1, 3, 'hAA55,  0, 0,  0, 3, 3, 3,   'hAA55, 'hAA55, 0, 0, 0,  0, 0);
        tbl[6]  = row(0, 0, 0, 0,       1, 7,  0, 3, 7, 3,   'hAA55, 0,      0, 0, 0,  1, 'h55);
        tbl[7]  = row(0, 0, 0, 0,       1, 8,  0, 7, 8, 0,   0,      0,      1, 0, 0,  2, 0);
        tbl[8]  = row(0, 0, 0, 0,       1, 9,  0, 8, 9, 0,   0,      0,      1, 0, 0,  3, 0);
        tbl[9]  = row(0, 0, 0, 0,       1, 4,  1, 7, 9, 0,   0,      0,      1, 1, 0,  1, 0);
        tbl[10] = row(0, 0, 0, 0,       0, 0,  0, 4, 7, 0,   0,      0,      1, 0, 0,  1, 0);
        tbl[11] = row(0, 0, 0, 0,       1, 6,  0, 9, 6, 0,   0,      0,      0, 0, 0,  2, 0);
        tbl[12] = row(0, 0, 0, 0,       1, 6,  0, 6, 4, 0,   0,      0,      1, 1, 1,  2, 0);
        tbl[13] = row(0, 1, 6, 'h66,    1, 6,  0, 6, 4, 6,   'h66,   0,      0, 1, 0,  2, 0);
        tbl[14] = row(1, 1, 11, 'hBB,   1, 10, 0, 6, 5, 6,   'h66,   D,      1, 0, 0,  0, 0);
        tbl[15] = row(0, 0, 0, 0,       0, 0,  0, 6, 5, 5,   0,      0,      0, 0, 0,  0, 0);
        tbl[16] = row(0, 0, 0, 0,       0, 0,  0, 10, 11, 0, 0,      0,      0, 0, 0,  0, 0);

        run(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        for (int i = 0; i < NREGS; i++)
            run(row(0, 0, 0, 0, 0, 0, 0, i, NREGS-1-i, i, 0, 0, 0, 0, 0, 0, 0), 1, 0);
        for (int i = 0; i < 17; i++) run(tbl[i], 1, 0);

        for (int i = 0; i < 500; i++) begin
            vec_t v;
            v = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst = ($urandom_range(0, 49) == 0);
            v.wbe = $urandom_range(0, 1) == 1;
            v.wrd = pick();
            v.wdata = {$urandom, $urandom};
            v.isse = $urandom_range(0, 1) == 1;
            v.ird = pick();
            v.fl = ($urandom_range(0, 11) == 0);
            v.rs1 = pick(); v.rs2 = pick(); v.dbg = pick();
            run(v, 1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
